// File: rtl/score_seg_encoder.sv
// Converts a 20-bit binary score to six active-low 7-segment digits.
// Uses serial double-dabble with a fixed 22-cycle request-to-request period.
module score_seg_encoder #(
    parameter logic [7:0] DASH  = 8'hBF,
    parameter logic [7:0] BLANK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] value,
    input  logic        blank_lz,
    output logic        busy,
    output logic        done,
    output logic [7:0]  Seg0,
    output logic [7:0]  Seg1,
    output logic [7:0]  Seg2,
    output logic [7:0]  Seg3,
    output logic [7:0]  Seg4,
    output logic [7:0]  Seg5
);

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    state_t           state_q, state_d;
    logic [19:0]      bin_q, bin_d;
    logic [23:0]      bcd_q, bcd_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             blz_q, blz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [5:0][7:0]  seg_q, seg_d;
    logic [5:0][7:0]  seg_enc;
    logic [23:0]      bcd_adj;

    function automatic logic [7:0] enc_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [23:0] dabble_adj(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digits above the most significant nonzero digit are blanked; Seg0 always lit.
    always_comb begin
        logic       lit;
        logic [3:0] digit;
        lit     = 1'b0;
        digit   = 4'd0;
        seg_enc = '0;
        for (int i = 5; i >= 0; i--) begin
            digit = bcd_q[4*i +: 4];
            if (digit != 4'd0 || i == 0) lit = 1'b1;
            if (ovf_q)
                seg_enc[i] = DASH;
            else if (blz_q && !lit)
                seg_enc[i] = BLANK;
            else
                seg_enc[i] = enc_digit(digit);
        end
    end

    assign bcd_adj = dabble_adj(bcd_q);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        blz_d   = blz_q;
        ovf_d   = ovf_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = value;
                    blz_d   = blank_lz;
                    ovf_d   = (value > 20'd999999);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[22:0], bin_q[19]};
                bin_d = {bin_q[18:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd19) state_d = ENCODE;
            end
            ENCODE: begin
                seg_d   = seg_enc;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            blz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= {6{DASH}};
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            blz_q   <= blz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign Seg0 = seg_q[0];
    assign Seg1 = seg_q[1];
    assign Seg2 = seg_q[2];
    assign Seg3 = seg_q[3];
    assign Seg4 = seg_q[4];
    assign Seg5 = seg_q[5];

endmodule

// File: tb/tb_score_seg_encoder.sv
// Scoreboard bench for score_seg_encoder: stimulus pushes expected segment
// words, a negedge monitor pops and compares on every done pulse.
module tb_score_seg_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] value;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [7:0]  Seg0, Seg1, Seg2, Seg3, Seg4, Seg5;
    logic [47:0] seg_all;

    int total = 0;
    int bad   = 0;
    logic [47:0] sb_q[$];

    localparam logic [47:0] ALL_DASH = 48'hBFBFBFBFBFBF;

    score_seg_encoder dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .blank_lz(blank_lz),
        .busy(busy), .done(done),
        .Seg0(Seg0), .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3), .Seg4(Seg4), .Seg5(Seg5)
    );

    always #5 clk = ~clk;

    assign seg_all = {Seg5, Seg4, Seg3, Seg2, Seg1, Seg0};

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] dig7(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'h00;
        endcase
    endfunction

    // Decimal reference built with divide/modulo, independent of double-dabble.
    function automatic logic [47:0] ref_seg(input int v, input bit blz);
        logic [47:0] r;
        int p, msd;
        r = '0;
        if (v > 999999) return ALL_DASH;
        msd = 0;
        p = v;
        for (int i = 0; i < 6; i++) begin
            if (p % 10 != 0) msd = i;
            p = p / 10;
        end
        p = v;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = (blz && i > msd) ? 8'hFF : dig7(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", seg_all, '1);
                    check_int("unexpected_done_cnt", 1, 0);
                end else begin
                    check("seg_out", seg_all, sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion: start sampled at edge k, sample s taken just after edge k+s.
    task automatic run_conv(input logic [19:0] v, input logic blz, input logic [47:0] exp,
                            input bit chk_timing, input string nm);
        int busy_cnt, done_first, done_cnt;
        value    = v;
        blank_lz = blz;
        start    = 1'b1;
        sb_q.push_back(exp);
        tick();
        start      = 1'b0;
        busy_cnt   = 0;
        done_first = -1;
        done_cnt   = 0;
        for (int s = 0; s < 26; s++) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (done_first < 0) done_first = s;
                done_cnt++;
            end
            if (done_first >= 0 && s == done_first + 1) break;
            tick();
        end
        check_int({nm, "_done_latency"}, done_first, 21);
        if (chk_timing) begin
            check_int({nm, "_busy_cycles"}, busy_cnt, 21);
            check_int({nm, "_done_width"}, done_cnt, 1);
        end
    endtask

    initial begin
        int dpos[$];
        int changes, done_first, done_cnt;
        logic [47:0] prev;

        rst = 1'b1; start = 1'b0; value = '0; blank_lz = 1'b0;
        repeat (3) tick();
        check("reset_seg", seg_all, ALL_DASH);
        check_int("reset_done", int'(done), 0);
        check_int("reset_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        run_conv(20'd123456, 1'b0, 48'hF9A4B0999282, 1'b1, "v123456");
        run_conv(20'd42,     1'b1, 48'hFFFFFFFF99A4, 1'b0, "v42_blank");
        run_conv(20'd42,     1'b0, 48'hC0C0C0C099A4, 1'b0, "v42");
        run_conv(20'd0,      1'b1, 48'hFFFFFFFFFFC0, 1'b0, "v0_blank");
        run_conv(20'd999999, 1'b0, 48'h909090909090, 1'b0, "v999999");
        run_conv(20'd1000000,1'b1, ALL_DASH,         1'b1, "v1000000");

        // start held high: accepts at k, k+22, k+44 with the value present then
        value = 20'd111111; blank_lz = 1'b0; start = 1'b1;
        sb_q.push_back(48'hF9F9F9F9F9F9);
        sb_q.push_back(48'hA4A4A4A4A4A4);
        sb_q.push_back(48'hB0B0B0B0B0B0);
        tick();
        for (int s = 0; s < 70; s++) begin
            if (done) dpos.push_back(s);
            if (s == 1)  value = 20'd222222;
            if (s == 23) value = 20'd333333;
            if (s == 44) start = 1'b0;
            tick();
        end
        check_int("held_done_count", dpos.size(), 3);
        while (dpos.size() < 3) dpos.push_back(-1);
        check_int("held_done0", dpos[0], 21);
        check_int("held_done1", dpos[1], 43);
        check_int("held_done2", dpos[2], 65);

        // start pulses mid-conversion are ignored, outputs hold until done
        prev = 48'hB0B0B0B0B0B0;
        value = 20'd555555; start = 1'b1;
        sb_q.push_back(48'h929292929292);
        tick();
        start = 1'b0;
        changes = 0; done_first = -1;
        for (int s = 0; s < 23; s++) begin
            if (s < 21 && seg_all !== prev) changes++;
            if (done && done_first < 0) done_first = s;
            if (s == 4) begin start = 1'b1; value = 20'd888888; end
            if (s == 5) start = 1'b0;
            if (s == 9) start = 1'b1;
            if (s == 10) start = 1'b0;
            tick();
        end
        check_int("ignore_seg_changes", changes, 0);
        check_int("ignore_done_latency", done_first, 21);

        // reset at edge k+10 aborts, restart at k+12 finishes at k+33
        value = 20'd777777; start = 1'b1;
        tick();
        start = 1'b0;
        done_first = -1; done_cnt = 0;
        for (int s = 0; s < 40; s++) begin
            if (done) begin
                if (done_first < 0) done_first = s;
                done_cnt++;
            end
            if (s == 9) rst = 1'b1;
            if (s == 10) begin
                check_int("abort_busy", int'(busy), 0);
                check("abort_seg", seg_all, ALL_DASH);
                rst = 1'b0;
            end
            if (s == 11) begin
                value = 20'd654321; start = 1'b1;
                sb_q.push_back(48'h829299B0A4F9);
            end
            if (s == 12) start = 1'b0;
            tick();
        end
        check_int("abort_done_latency", done_first, 33);
        check_int("abort_done_count", done_cnt, 1);

        for (int n = 0; n < 1000; n++) begin
            int  v;
            bit  b;
            v = int'($urandom_range(0, 999999));
            b = 1'($urandom_range(0, 1));
            run_conv(20'(v), b, ref_seg(v, b), 1'b0, "rand");
        end

        repeat (3) tick();
        check_int("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
